// File: rtl/dicke_sequencer.sv
// Dicke-switch sequencer: drives the reference/antenna switch and integrates
// ADC samples per phase over NUM_PERIODS periods, with a valid/ready result.
module dicke_sequencer #(
    parameter int HALF_PERIOD  = 5000,
    parameter int BLANK_CYCLES = 500,
    parameter int NUM_PERIODS  = 100,
    parameter int SAMPLE_W     = 12,
    parameter int ACC_W        = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                result_ready,
    output logic                switch_pwm,
    output logic                busy,
    output logic                result_valid,
    output logic [ACC_W-1:0]    sum_ref,
    output logic [ACC_W-1:0]    sum_ant,
    output logic [ACC_W:0]      diff,
    output logic                sat,
    output logic                overrun
);
    localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int PC_W = $clog2(NUM_PERIODS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic [PC_W-1:0]   period_cnt_q, period_cnt_d;
    logic              sw_q, sw_d;
    logic [ACC_W-1:0]  acc_ref_q, acc_ref_d, acc_ant_q, acc_ant_d;
    logic              res_valid_q, res_valid_d;
    logic [ACC_W-1:0]  sum_ref_q, sum_ref_d, sum_ant_q, sum_ant_d;
    logic [ACC_W:0]    diff_q, diff_d;
    logic              sat_q, sat_d, overrun_q, overrun_d;

    logic              run, blank, accept, last_cyc, eoi;
    logic [ACC_W:0]    ref_sum, ant_sum;
    logic [ACC_W-1:0]  acc_ref_n, acc_ant_n;

    generate
        if (BLANK_CYCLES == 0) begin : g_noblank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = phase_cnt_q < PH_W'(BLANK_CYCLES);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        phase_cnt_d  = phase_cnt_q;
        period_cnt_d = period_cnt_q;
        sw_d         = sw_q;
        acc_ref_d    = acc_ref_q;
        acc_ant_d    = acc_ant_q;
        res_valid_d  = res_valid_q;
        sum_ref_d    = sum_ref_q;
        sum_ant_d    = sum_ant_q;
        diff_d       = diff_q;
        sat_d        = sat_q;
        overrun_d    = overrun_q;

        run      = (state_q == RUN);
        accept   = run && !blank && sample_valid;
        last_cyc = run && (phase_cnt_q == PH_W'(HALF_PERIOD - 1));
        eoi      = last_cyc && !sw_q && (period_cnt_q == PC_W'(NUM_PERIODS - 1));

        // Saturating adds; acc_*_n include this cycle's sample so that the
        // end-of-integration cycle contributes to the result.
        ref_sum   = {1'b0, acc_ref_q} + (ACC_W + 1)'(sample_data);
        ant_sum   = {1'b0, acc_ant_q} + (ACC_W + 1)'(sample_data);
        acc_ref_n = acc_ref_q;
        acc_ant_n = acc_ant_q;
        if (accept && sw_q) begin
            acc_ref_n = ref_sum[ACC_W] ? '1 : ref_sum[ACC_W-1:0];
            if (ref_sum[ACC_W]) sat_d = 1'b1;
        end
        if (accept && !sw_q) begin
            acc_ant_n = ant_sum[ACC_W] ? '1 : ant_sum[ACC_W-1:0];
            if (ant_sum[ACC_W]) sat_d = 1'b1;
        end

        if (res_valid_q && result_ready) res_valid_d = 1'b0;
        if (eoi) begin
            if (!res_valid_q || result_ready) begin
                res_valid_d = 1'b1;
                sum_ref_d   = acc_ref_n;
                sum_ant_d   = acc_ant_n;
                diff_d      = {1'b0, acc_ant_n} - {1'b0, acc_ref_n};
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                phase_cnt_d  = '0;
                period_cnt_d = '0;
                acc_ref_d    = '0;
                acc_ant_d    = '0;
                sw_d         = 1'b0;
                if (enable) begin
                    state_d = RUN;
                    sw_d    = 1'b1;
                end
            end
            RUN: begin
                phase_cnt_d = last_cyc ? '0 : phase_cnt_q + PH_W'(1);
                sw_d        = last_cyc ? ~sw_q : sw_q;
                if (last_cyc && !sw_q) period_cnt_d = period_cnt_q + PC_W'(1);
                acc_ref_d = acc_ref_n;
                acc_ant_d = acc_ant_n;
                if (eoi) begin
                    period_cnt_d = '0;
                    acc_ref_d    = '0;
                    acc_ant_d    = '0;
                end
                if (!enable) begin
                    state_d      = IDLE;
                    sw_d         = 1'b0;
                    phase_cnt_d  = '0;
                    period_cnt_d = '0;
                    acc_ref_d    = '0;
                    acc_ant_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            phase_cnt_q  <= '0;
            period_cnt_q <= '0;
            sw_q         <= 1'b0;
            acc_ref_q    <= '0;
            acc_ant_q    <= '0;
            res_valid_q  <= 1'b0;
            sum_ref_q    <= '0;
            sum_ant_q    <= '0;
            diff_q       <= '0;
            sat_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_cnt_q  <= phase_cnt_d;
            period_cnt_q <= period_cnt_d;
            sw_q         <= sw_d;
            acc_ref_q    <= acc_ref_d;
            acc_ant_q    <= acc_ant_d;
            res_valid_q  <= res_valid_d;
            sum_ref_q    <= sum_ref_d;
            sum_ant_q    <= sum_ant_d;
            diff_q       <= diff_d;
            sat_q        <= sat_d;
            overrun_q    <= overrun_d;
        end
    end

    assign switch_pwm   = sw_q;
    assign busy         = (state_q == RUN);
    assign result_valid = res_valid_q;
    assign sum_ref      = sum_ref_q;
    assign sum_ant      = sum_ant_q;
    assign diff         = diff_q;
    assign sat          = sat_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_dicke_sequencer.sv
// Directed bench for dicke_sequencer: two instances (ACC_W=20 and ACC_W=14)
// share stimulus; expected values are hand-computed for HALF_PERIOD=8, BLANK=2, NUM_PERIODS=2.
module tb_dicke_sequencer;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_data = '0;
    logic        result_ready = 1'b0;

    logic        a_pwm, a_busy, a_rv, a_sat, a_ovr;
    logic [19:0] a_ref, a_ant;
    logic [20:0] a_diff;
    logic        s_pwm, s_busy, s_rv, s_sat, s_ovr;
    logic [13:0] s_ref, s_ant;
    logic [14:0] s_diff;

    int tests = 0;
    int fails = 0;
    int rc = 0;
    int ref_tab[4];
    logic blank_mode = 1'b0;

    localparam logic [20:0] E_D1  = 21'(480 - 1200);
    localparam logic [20:0] E_DA4 = 21'(480 - 49140);
    localparam logic [14:0] E_DS4 = 15'(480 - 16383);

    always #5 clk = ~clk;

    dicke_sequencer #(.HALF_PERIOD(8), .BLANK_CYCLES(2), .NUM_PERIODS(2),
                      .SAMPLE_W(12), .ACC_W(20)) u_a (
        .clk(clk), .clr(clr), .enable(enable), .sample_valid(sample_valid),
        .sample_data(sample_data), .result_ready(result_ready),
        .switch_pwm(a_pwm), .busy(a_busy), .result_valid(a_rv),
        .sum_ref(a_ref), .sum_ant(a_ant), .diff(a_diff), .sat(a_sat), .overrun(a_ovr));

    dicke_sequencer #(.HALF_PERIOD(8), .BLANK_CYCLES(2), .NUM_PERIODS(2),
                      .SAMPLE_W(12), .ACC_W(14)) u_s (
        .clk(clk), .clr(clr), .enable(enable), .sample_valid(sample_valid),
        .sample_data(sample_data), .result_ready(result_ready),
        .switch_pwm(s_pwm), .busy(s_busy), .result_valid(s_rv),
        .sum_ref(s_ref), .sum_ant(s_ant), .diff(s_diff), .sat(s_sat), .overrun(s_ovr));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs for run cycle rc: reference half when (rc % 16) < 8.
    task automatic drive();
        sample_valid = blank_mode ? ((rc % 8) < 2) : 1'b1;
        sample_data  = 12'(((rc % 16) < 8) ? ref_tab[(rc / 32) % 4] : 40);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rc++;
        drive();
    endtask

    task automatic run_to(input int n);
        while (rc < n) step();
    endtask

    task automatic start_run();
        enable = 1'b1;
        @(posedge clk);
        #1;
        rc = 0;
        drive();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        ref_tab = '{100, 100, 100, 100};
        @(posedge clk);
        #1;
        do_clr();
        chk("rst_busy", a_busy, 0);
        chk("rst_pwm", a_pwm, 0);
        chk("rst_rv", a_rv, 0);
        chk("rst_ref", a_ref, 0);
        chk("rst_diff", a_diff, 0);
        chk("rst_sat", a_sat, 0);
        chk("rst_ovr", a_ovr, 0);

        // Basic run, consumer always ready
        result_ready = 1'b1;
        start_run();
        chk("s1_busy0", a_busy, 1);
        chk("s1_pwm0", a_pwm, 1);
        run_to(7);  chk("s1_pwm7", a_pwm, 1);
        run_to(8);  chk("s1_pwm8", a_pwm, 0);
        run_to(16); chk("s1_pwm16", a_pwm, 1);
        run_to(31); chk("s1_rv31", a_rv, 0);
        run_to(32);
        chk("s1_rv32", a_rv, 1);
        chk("s1_ref", a_ref, 1200);
        chk("s1_ant", a_ant, 480);
        chk("s1_diff", a_diff, E_D1);
        chk("s1_sat", a_sat, 0);
        run_to(33); chk("s1_rv33", a_rv, 0);
        enable = 1'b0;
        step();
        chk("s1_idle_busy", a_busy, 0);
        chk("s1_idle_pwm", a_pwm, 0);

        // Backpressure: same-cycle handshake, then a dropped result
        ref_tab = '{100, 50, 70, 70};
        result_ready = 1'b0;
        start_run();
        run_to(32);
        chk("s2_rv32", a_rv, 1);
        chk("s2_ref32", a_ref, 1200);
        run_to(63);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("s2_rv64", a_rv, 1);
        chk("s2_ref64", a_ref, 600);
        chk("s2_ovr64", a_ovr, 0);
        run_to(65); chk("s2_rv65", a_rv, 1);
        run_to(95); chk("s2_ovr95", a_ovr, 0);
        run_to(96);
        chk("s2_ovr96", a_ovr, 1);
        chk("s2_rv96", a_rv, 1);
        chk("s2_ref96", a_ref, 600);
        enable = 1'b0;
        step();
        chk("s2_idle_busy", a_busy, 0);

        // Drop enable mid-run with a held result
        ref_tab = '{100, 100, 100, 100};
        start_run();
        run_to(13);
        enable = 1'b0;
        step();
        chk("s3_pwm", a_pwm, 0);
        chk("s3_busy", a_busy, 0);
        chk("s3_rv", a_rv, 1);
        chk("s3_ref", a_ref, 600);
        chk("s3_ovr", a_ovr, 1);
        run_to(40);
        chk("s3_rv40", a_rv, 1);
        chk("s3_ref40", a_ref, 600);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("s3_rv_hs", a_rv, 0);

        // Saturation on the narrow instance
        do_clr();
        chk("s4_clr_ovr", a_ovr, 0);
        chk("s4_clr_ref", a_ref, 0);
        ref_tab = '{4095, 4095, 4095, 4095};
        start_run();
        run_to(32);
        chk("s4_s_rv", s_rv, 1);
        chk("s4_s_ref", s_ref, 16383);
        chk("s4_s_sat", s_sat, 1);
        chk("s4_s_ant", s_ant, 480);
        chk("s4_s_diff", s_diff, E_DS4);
        chk("s4_a_ref", a_ref, 49140);
        chk("s4_a_sat", a_sat, 0);
        chk("s4_a_diff", a_diff, E_DA4);
        enable = 1'b0;
        step();

        // clr mid-run clears everything, including held result and sat
        ref_tab = '{100, 100, 100, 100};
        start_run();
        run_to(20);
        clr = 1'b1;
        enable = 1'b0;
        step();
        clr = 1'b0;
        chk("s6_busy", a_busy, 0);
        chk("s6_pwm", a_pwm, 0);
        chk("s6_rv", a_rv, 0);
        chk("s6_ref", a_ref, 0);
        chk("s6_ant", a_ant, 0);
        chk("s6_diff", a_diff, 0);
        chk("s6_s_sat", s_sat, 0);
        run_to(45);
        chk("s6_rv45", a_rv, 0);
        chk("s6_busy45", a_busy, 0);

        // Samples only in blank cycles
        blank_mode = 1'b1;
        result_ready = 1'b1;
        start_run();
        run_to(32);
        chk("s5_rv", a_rv, 1);
        chk("s5_ref", a_ref, 0);
        chk("s5_ant", a_ant, 0);
        chk("s5_diff", a_diff, 0);
        enable = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
